// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the data-bus SRAM responder: bus request/response structs,
// the responder state enum and the word-index width helper.
package dbus_sram_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } respState_e;

    localparam int LAT_CNT_W = 4;

    // A single-word array still needs a one-bit index to keep port widths legal.
    function automatic int indexWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dbus_sram_responder_strobe_ram.sv
// Single-port 64-bit word array with per-byte write enables and a registered
// read port; the read register holds its value until the next read enable.
module strobe_ram
    import dbus_sram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = indexWidth(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic             readEn,
    input  logic [7:0]       byteWe,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (byteWe[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (readEn) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus target backed by a byte-strobed word array: accepts one request in
// IDLE, waits a fixed latency, then answers with a one-cycle data_ok pulse.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int                   IDX_W    = indexWidth(DEPTH_WORDS);
    localparam logic [LAT_CNT_W-1:0] LOAD_CNT = LAT_CNT_W'(LATENCY - 1);

    function automatic logic inRange(input logic [63:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 3) < 64'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] wordIndex(input logic [63:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    respState_e           state, nextState;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 accept;
    logic                 addrOk;
    logic                 dataOkQ;
    logic                 readValidQ;
    logic                 enteringResp;
    logic                 reqRead;

    logic [IDX_W-1:0]     idxQ;
    logic [7:0]           strobeQ;
    logic [63:0]          dataQ;
    logic                 writeQ;
    logic                 inRangeQ;

    logic [IDX_W-1:0]     ramAddr;
    logic                 ramReadEn;
    logic [7:0]           ramByteWe;
    logic [63:0]          ramRdata;

    logic [2:0]           unusedSize;

    assign unusedSize = dreq.size;

    always_comb begin
        nextState = state;
        addrOk    = 1'b0;
        case (state)
            IDLE: begin
                addrOk = dreq.valid;
                if (dreq.valid) begin
                    nextState = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == LAT_CNT_W'(1)) begin
                    nextState = RESP;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign accept       = (state == IDLE) && dreq.valid;
    assign enteringResp = (nextState == RESP) && (state != RESP);

    // With LATENCY=1 the read is launched in the accept cycle itself, before the
    // latched copy exists, so the array address comes straight from the request.
    always_comb begin
        ramAddr   = idxQ;
        reqRead   = !writeQ && inRangeQ;
        ramReadEn = 1'b0;
        ramByteWe = 8'h00;
        if (state == IDLE) begin
            ramAddr = wordIndex(dreq.addr);
            reqRead = (dreq.strobe == 8'h00) && inRange(dreq.addr);
        end
        if (!reset && enteringResp && reqRead) begin
            ramReadEn = 1'b1;
        end
        if (!reset && (state == RESP) && writeQ && inRangeQ) begin
            ramByteWe = strobeQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dataOkQ    <= 1'b0;
            readValidQ <= 1'b0;
        end else begin
            state   <= nextState;
            dataOkQ <= (nextState == RESP);
            if (enteringResp) begin
                readValidQ <= reqRead;
            end
            if (accept) begin
                cnt <= LOAD_CNT;
            end else if (state == WAIT) begin
                cnt <= cnt - LAT_CNT_W'(1);
            end
        end
    end

    // The latched request is authoritative for the rest of the transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            idxQ     <= wordIndex(dreq.addr);
            strobeQ  <= dreq.strobe;
            dataQ    <= dreq.data;
            writeQ   <= (dreq.strobe != 8'h00);
            inRangeQ <= inRange(dreq.addr);
        end
    end

    strobe_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) uRam (
        .clk   (clk),
        .addr  (ramAddr),
        .readEn(ramReadEn),
        .byteWe(ramByteWe),
        .wdata (dataQ),
        .rdata (ramRdata)
    );

    assign dresp.addr_ok = addrOk;
    assign dresp.data_ok = dataOkQ;
    assign dresp.data    = readValidQ ? ramRdata : 64'h0;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for the held-request throughput check.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  dreq1;
    dbus_resp_t dresp1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dbus_sram_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (2),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .dreq (dreq),
        .dresp(dresp)
    );

    dbus_sram_responder #(
        .DEPTH_WORDS(16),
        .LATENCY    (1),
        .BASE_ADDR  (BASE)
    ) dut1 (
        .clk  (clk),
        .reset(reset),
        .dreq (dreq1),
        .dresp(dresp1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One full transaction on the LATENCY=2 instance; the request is scrambled
    // after the accept cycle so only the latched copy can produce the result.
    task automatic applyStimulus(input string tag, input logic [63:0] addr, input logic [7:0] strobe,
                                 input logic [63:0] wdata, input logic [63:0] expData);
        int cyc;
        @(posedge clk); #1;
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = 3'd3;
        dreq.strobe = strobe;
        dreq.data   = wdata;
        @(negedge clk);
        checkOutput({tag, "_aok"}, 64'(dresp.addr_ok), 64'd1);
        checkOutput({tag, "_dok0"}, 64'(dresp.data_ok), 64'd0);
        @(posedge clk); #1;
        dreq.valid  = 1'b0;
        dreq.addr   = ~addr;
        dreq.strobe = ~strobe;
        dreq.data   = ~wdata;
        cyc = 1;
        @(negedge clk);
        while (!dresp.data_ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_lat"}, 64'(cyc), 64'd2);
        checkOutput({tag, "_data"}, dresp.data, expData);
        checkOutput({tag, "_aokResp"}, 64'(dresp.addr_ok), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 64'(dresp.data_ok), 64'd0);
    endtask

    initial begin
        dreq  = '0;
        dreq1 = '0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle%0d_aok", i), 64'(dresp.addr_ok), 64'd0);
            checkOutput($sformatf("idle%0d_dok", i), 64'(dresp.data_ok), 64'd0);
            checkOutput($sformatf("idle%0d_data", i), dresp.data, 64'd0);
        end

        applyStimulus("wrFull", 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
        applyStimulus("rdFull", 64'h8000_0010, 8'h00, 64'h0, 64'h1122_3344_5566_7788);
        applyStimulus("wrPart", 64'h8000_0010, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, 64'h0);
        applyStimulus("rdPart", 64'h8000_0010, 8'h00, 64'h0, 64'h1122_3344_AAAA_BBBB);

        applyStimulus("rdLow", 64'h7FFF_FFF8, 8'h00, 64'h0, 64'h0);
        applyStimulus("wrW0", BASE, 8'hFF, 64'h0BAD_F00D_1234_5678, 64'h0);
        applyStimulus("wrHigh", BASE + 64'(8 * 1024), 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        applyStimulus("rdW0", BASE, 8'h00, 64'h0, 64'h0BAD_F00D_1234_5678);

        // Reset lands in the WAIT cycle of a write to word 5.
        applyStimulus("wrW5", BASE + 64'h28, 8'hFF, 64'h5555, 64'h0);
        @(posedge clk); #1;
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'h28;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD;
        @(negedge clk);
        checkOutput("rstAccept_aok", 64'(dresp.addr_ok), 64'd1);
        @(posedge clk); #1;
        dreq.valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        checkOutput("rstWait_dok", 64'(dresp.data_ok), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstHeld_dok", 64'(dresp.data_ok), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstAfter_dok", 64'(dresp.data_ok), 64'd0);
        applyStimulus("rdW5", BASE + 64'h28, 8'h00, 64'h0, 64'h5555);

        // LATENCY=1 instance: seed word 0, then hold a read request for 8 cycles.
        @(posedge clk); #1;
        dreq1.valid  = 1'b1;
        dreq1.addr   = BASE;
        dreq1.size   = 3'd3;
        dreq1.strobe = 8'hFF;
        dreq1.data   = 64'hCAFE;
        @(negedge clk);
        checkOutput("l1Wr_aok", 64'(dresp1.addr_ok), 64'd1);
        @(posedge clk); #1;
        dreq1.valid = 1'b0;
        @(negedge clk);
        checkOutput("l1Wr_dok", 64'(dresp1.data_ok), 64'd1);
        @(posedge clk); #1;
        dreq1.valid  = 1'b1;
        dreq1.strobe = 8'h00;
        dreq1.data   = 64'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("held%0d_aok", k), 64'(dresp1.addr_ok), 64'((k % 2) == 0));
            checkOutput($sformatf("held%0d_dok", k), 64'(dresp1.data_ok), 64'((k % 2) == 1));
            if ((k % 2) == 1) begin
                checkOutput($sformatf("held%0d_data", k), dresp1.data, 64'hCAFE);
            end
        end
        @(posedge clk); #1;
        dreq1.valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Data-bus target for the pipeline's memory stage. It accepts dbus_req_t requests and answers with dbus_resp_t over the addr_ok/data_ok handshake.
- Backed by a byte-strobed 64-bit word array with a fixed, parameterised access latency.
- Used as the simulation and FPGA data memory, so the memory stage can be exercised without the external bus bridge.

Parameters:
- DEPTH_WORDS, 1024: number of 64-bit words in the array; a power of two.
- LATENCY, 2: cycles from the accept cycle to the data_ok cycle; legal range 1..15.
- BASE_ADDR, 64'h8000_0000: byte address mapped to word 0.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- dreq  input  dbus_req_t  request fields: valid, addr[63:0], size, strobe[7:0], data[63:0].
- dresp  output  dbus_resp_t  response fields: addr_ok, data_ok, data[63:0].

Behaviour:
- Reset (synchronous, active-high): state=IDLE, latency counter=0, dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0. Array contents are not cleared; load them from a $readmemh hook under a define.
- State IDLE:
  - dresp.addr_ok = dreq.valid, combinationally. This is the accept cycle.
  - On the accept edge: latch addr, strobe and data; set write = (strobe != 0); load counter with LATENCY-1.
  - Next state is WAIT if LATENCY>1, else RESP.
- State WAIT:
  - addr_ok=0, data_ok=0; decrement counter.
  - Go to RESP on the edge where counter==1.
  - Inputs are ignored; the latched copy is authoritative even if dreq.valid drops or dreq changes.
- State RESP: data_ok=1 for exactly one cycle; addr_ok=0; next state is IDLE.
  - Read: dresp.data = array word at the latched index. The word is sampled on the edge entering RESP and held registered until the next RESP.
  - Write: dresp.data = 0. Bytes i with strobe[i]=1 are committed on the edge leaving RESP; other bytes are unchanged.
- Index = (addr - BASE_ADDR) >> 3. addr[2:0] is ignored; strobe alone selects bytes and size is not interpreted.
- Out of range means addr < BASE_ADDR or index >= DEPTH_WORDS.
  - Read returns 64'h0.
  - Write is dropped.
  - The handshake still completes normally; it must never hang.
- Throughput: one transaction per LATENCY+1 cycles. A request held valid through the data_ok cycle is not re-accepted in that cycle. It is accepted in the following IDLE cycle, where it is treated as a new transaction, so the master must drop or change valid after data_ok.
- Read-after-write to the same word: the write commits on the edge leaving RESP, so any later read observes the new bytes.
- Reset mid-transaction (WAIT or RESP): return to IDLE. No write is committed and data_ok=0 from the next cycle.
- Combinational paths: only dreq.valid -> dresp.addr_ok. data_ok and data are registered.

Decomposition:
- Shared package (common): responder state enum (IDLE, WAIT, RESP) and the word-index width derivation helper.
- dbus_req_t and dbus_resp_t stay as already defined in common.
- One sub-module: strobe_ram. It is a single-port DEPTH_WORDS x 64 array with an 8-bit byte write enable and registered read, instantiated once. The FSM, counter and range check live in the top module.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then dreq.valid=0 for 10 cycles -> addr_ok, data_ok and data stay 0 throughout.
- Full write then read, LATENCY=2:
  - Write to 64'h8000_0010 with strobe 8'hFF, data 64'h1122_3344_5566_7788 -> addr_ok in cycle 0, data_ok only in cycle 2, dresp.data=0.
  - Read of the same address -> data_ok 2 cycles after its accept, data=64'h1122_3344_5566_7788.
- Partial write: write strobe 8'h0F, data 64'hFFFF_FFFF_AAAA_BBBB over the word above, then read -> 64'h1122_3344_AAAA_BBBB.
- Out of range:
  - Read of 64'h7FFF_FFF8 -> data_ok with data=0.
  - Write to BASE_ADDR + 8*DEPTH_WORDS, then read of word 0 -> word 0 is unchanged and no hang occurs.
- Held request: valid held high with a constant read request for 8 cycles, LATENCY=1 -> addr_ok in cycles 0, 2, 4, 6 and data_ok in cycles 1, 3, 5, 7.
- Reset mid-operation: accept a write of 64'hDEAD to word 5, assert reset in the WAIT cycle, then read word 5 -> old value returned and no data_ok during reset.
